decade_tick_gen: RTL and testbench

DECADE_TICK_GEN -- requirements
Module: decade_tick_gen

---
 rtl/decade_tick_gen_pkg.sv | 17 +
 rtl/decade_tick_gen_digit.sv | 53 +++++
 rtl/decade_tick_gen.sv | 61 ++++++
 tb/tb_decade_tick_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/decade_tick_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decade_tick_gen_pkg
// Purpose  : Shared BCD constants and digit type for the decade tick chain.
// Revision : 1.0 - initial release
// ============================================================================
package decade_tick_gen_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

endpackage
`default_nettype wire

// File: rtl/decade_tick_gen_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_ud
// Purpose  : One up/down BCD decade with clear, saturating load and step.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_ud
    import decade_tick_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up_dn,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t load_digit,
    output bcd_digit_t q,
    output logic       at_term
);

    bcd_digit_t r_q;
    bcd_digit_t w_load_sat;
    bcd_digit_t w_next_step;

    // Non-BCD preset codes clamp to 9 so the digit never leaves 0..9.
    assign w_load_sat = (load_digit > BCD_MAX) ? BCD_MAX : load_digit;

    always_comb begin
        w_next_step = r_q;
        if (up_dn) begin
            w_next_step = (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
        end else begin
            w_next_step = (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= BCD_MIN;
        end else if (clr) begin
            r_q <= BCD_MIN;
        end else if (load) begin
            r_q <= w_load_sat;
        end else if (step) begin
            r_q <= w_next_step;
        end
    end

    assign q       = r_q;
    assign at_term = up_dn ? (r_q == BCD_MAX) : (r_q == BCD_MIN);

endmodule
`default_nettype wire

// File: rtl/decade_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : decade_tick_gen
// Purpose  : Cascaded up/down BCD counter with per-decade rollover strobes.
// Revision : 1.0 - initial release
// ============================================================================
module decade_tick_gen
    import decade_tick_gen_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    up_dn,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic [NUM_DIGITS-1:0]   tick,
    output logic                    wrap
);

    logic [NUM_DIGITS-1:0] w_at_term;
    logic [NUM_DIGITS-1:0] w_chain;
    logic [NUM_DIGITS-1:0] w_step;
    logic                  w_count_ok;

    // Clear and load both suppress the carry chain outright.
    assign w_count_ok = en & ~clr & ~load;

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_digit
            if (i == 0) begin : g_lsd
                assign w_chain[i] = w_at_term[i];
                assign w_step[i]  = en;
            end else begin : g_upper
                assign w_chain[i] = w_chain[i-1] & w_at_term[i];
                assign w_step[i]  = tick[i-1];
            end

            bcd_digit_ud u_digit (
                .clk        (clk),
                .rst        (rst),
                .step       (w_step[i]),
                .up_dn      (up_dn),
                .clr        (clr),
                .load       (load),
                .load_digit (load_val[4*i +: 4]),
                .q          (count[4*i +: 4]),
                .at_term    (w_at_term[i])
            );
        end
    endgenerate

    assign tick = {NUM_DIGITS{w_count_ok}} & w_chain;
    assign wrap = tick[NUM_DIGITS-1];

endmodule
`default_nettype wire

// File: tb/tb_decade_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_decade_tick_gen
// Purpose  : Self-checking bench for decade_tick_gen with three decades.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decade_tick_gen;

    localparam int ND = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          load = 1'b0;
    logic [4*ND-1:0] load_val = '0;
    logic          up_dn = 1'b1;
    logic [4*ND-1:0] count;
    logic [ND-1:0] tick;
    logic          wrap;

    int vectors = 0;
    int miscompares = 0;
    int model = 0;

    decade_tick_gen #(.NUM_DIGITS(ND)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .up_dn    (up_dn),
        .count    (count),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int sat_load(input logic [4*ND-1:0] lv);
        int v;
        int p;
        int d;
        v = 0;
        p = 1;
        for (int k = 0; k < ND; k++) begin
            d = int'(lv[4*k +: 4]);
            if (d > 9) d = 9;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    // A decade rolls when the value modulo 10^(k+1) sits at its terminal.
    function automatic logic [ND-1:0] exp_tick(input int m, input logic e,
                                               input logic c, input logic l,
                                               input logic up);
        logic [ND-1:0] r;
        int p;
        r = '0;
        p = 10;
        for (int k = 0; k < ND; k++) begin
            if (e && !c && !l)
                r[k] = up ? ((m % p) == p - 1) : ((m % p) == 0);
            p = p * 10;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model <= 0;
        else if (clr) model <= 0;
        else if (load) model <= sat_load(load_val);
        else if (en) model <= up_dn ? (model + 1) % 1000 : (model + 999) % 1000;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [ND-1:0] et;
        et = exp_tick(model, en, clr, load, up_dn);
        check("model_count", 32'(count), 32'(to_bcd(model)));
        check("model_tick", 32'(tick), 32'(et));
        check("model_wrap", 32'(wrap), 32'(et[ND-1]));
    end

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic c, input logic l,
                         input logic [4*ND-1:0] lv, input logic up);
        #1;
        en = e; clr = c; load = l; load_val = lv; up_dn = up;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2 check("async_reset_count", 32'(count), 32'h000);
        check("reset_tick", 32'(tick), 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Free-running up count across every decade boundary.
        drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b1);
        go(9);
        check("up_009_count", 32'(count), 32'h009);
        check("up_009_tick", 32'(tick), 32'b001);
        go(90);
        check("up_099_count", 32'(count), 32'h099);
        check("up_099_tick", 32'(tick), 32'b011);
        go(900);
        check("up_999_count", 32'(count), 32'h999);
        check("up_999_wrap", 32'(wrap), 32'h1);
        go(1);
        check("up_wrap_count", 32'(count), 32'h000);

        // Down count from 000 wraps immediately.
        drive(1'b0, 1'b0, 1'b1, 12'h000, 1'b0);
        go(1);
        drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        #1 check("down_000_tick", 32'(tick), 32'b111);
        check("down_000_wrap", 32'(wrap), 32'h1);
        go(1);
        check("down_wrap_count", 32'(count), 32'h999);

        // Clear beats load; strobes are masked.
        drive(1'b1, 1'b1, 1'b1, 12'h598, 1'b1);
        #1 check("clr_load_tick", 32'(tick), 32'h0);
        go(1);
        check("clr_load_count", 32'(count), 32'h000);

        drive(1'b0, 1'b0, 1'b1, 12'hA5F, 1'b1);
        go(1);
        check("sat_load_count", 32'(count), 32'h959);

        // Hold with en low.
        drive(1'b0, 1'b0, 1'b1, 12'h123, 1'b1);
        go(1);
        drive(1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        go(20);
        check("hold_count", 32'(count), 32'h123);
        check("hold_tick", 32'(tick), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b1);
        go(1);
        check("resume_count", 32'(count), 32'h124);

        // Direction flip re-evaluates tick in the same cycle.
        drive(1'b0, 1'b0, 1'b1, 12'h090, 1'b1);
        go(1);
        drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b1);
        #1 check("dir_up_tick", 32'(tick), 32'b000);
        drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
        #1 check("dir_down_tick", 32'(tick), 32'b001);
        go(1);
        check("dir_down_count", 32'(count), 32'h089);

        // Asynchronous reset in the middle of a count.
        drive(1'b0, 1'b0, 1'b1, 12'h456, 1'b1);
        go(1);
        check("load_456", 32'(count), 32'h456);
        drive(1'b1, 1'b0, 1'b0, 12'h000, 1'b1);
        #1 rst = 1'b1;
        #1 check("mid_reset_count", 32'(count), 32'h000);
        @(negedge clk);
        #1 rst = 1'b0;
        go(1);
        check("post_reset_count", 32'(count), 32'h001);

        go(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
